switch_debouncer: RTL
=====================

# switch_debouncer

Two-channel switch conditioner between the board's raw slide-switch pins and the switch inputs of `DMemory_IO`. Each channel has a 2-flop synchronizer and a counter-based debouncer. Outputs are the stable switch levels, one-cycle edge pulses, and sticky change flags that software-visible logic can clear. It removes metastability and contact bounce so that `PMIPSL0` programs polling switch 0/1 see clean levels.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive synchronized cycles a new level must persist before it is accepted. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, default 16: width of each channel's debounce counter.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw0_raw`  in  1  raw, asynchronous switch 0 pin.
- `sw1_raw`  in  1  raw, asynchronous switch 1 pin.
- `io_sw0`  out  1  debounced switch 0 level; drives `DMemory_IO` `io_sw0`.
- `io_sw1`  out  1  debounced switch 1 level; drives `DMemory_IO` `io_sw1`.
- `sw_rise`  out  2  one-cycle pulse on an accepted 0→1 transition. Bit i corresponds to switch i.
- `sw_fall`  out  2  one-cycle pulse on an accepted 1→0 transition.
- `sw_changed`  out  2  sticky flag: set on any accepted transition, held until cleared.
- `changed_clr`  in  2  synchronous clear for `sw_changed[i]`.

## Operation
- Per channel, `raw` → `sync1` → `sync2` (2-flop synchronizer). `s` = `sync2`. `q` = accepted level, driven on `io_swi`.
- Per-channel FSM:
  - STABLE:
    - If `s == q`: counter = 0, stay in STABLE.
    - If `s != q`: counter → 1, go to COUNTING.
  - COUNTING:
    - If `s == q`: counter → 0, return to STABLE. This is a bounce and is discarded.
    - If `s != q` and counter < DEBOUNCE_CYCLES−1: counter increments.
    - If `s != q` and counter == DEBOUNCE_CYCLES−1: `q ← s`, counter → 0, go to STABLE.
    - With DEBOUNCE_CYCLES = 1, the first `s != q` cycle accepts directly from STABLE.
- On an accepted transition, in the same edge that updates `q`:
  - `sw_rise[i]` or `sw_fall[i]` asserts for exactly one cycle, matching the direction.
  - `sw_changed[i]` sets.
- `changed_clr[i]` clears `sw_changed[i]` at the next edge.
  - Simultaneous set and clear: set wins and the flag stays 1.
  - `changed_clr` with no flag set has no effect.
- Counter arithmetic is unsigned CNT_W bits. The counter never exceeds DEBOUNCE_CYCLES−1, so it cannot wrap.
- The two channels are fully independent. Simultaneous transitions on both produce pulses on both bits in the same cycle.

## Timing
- Reset values: `sync1`, `sync2` = 0; `q` = 0, so `io_sw0` = `io_sw1` = 0. Counters = 0, FSMs = STABLE, `sw_rise` = `sw_fall` = `sw_changed` = 0.
- A switch held at 1 through reset is reported as an accepted 0→1 transition after reset deasserts, with normal latency.
- Latency: let edge 0 be the first edge at which `sync1` captures the new raw level. `q` and the pulses update at edge DEBOUNCE_CYCLES+1, provided the level holds throughout.
- Every output is a register. There is no combinational path from any input to any output.
- Reset asserted mid-count aborts the count. All state holds reset values at the edge after reset is sampled high. `sw_changed` is cleared by reset regardless of `changed_clr`.
- A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles never changes `q`.

## Structure
- Shared package `pmipsl_io_pkg` holds:
  - `NUM_SW = 2`.
  - FSM state typedef `db_state_t {DB_STABLE, DB_COUNTING}`.
  - Default `DEBOUNCE_CYCLES` constant.
- Sub-module `sw_debounce_chan` contains one channel: synchronizer, FSM, counter, pulse and sticky logic. The top instantiates it NUM_SW times and maps the channel outputs to `io_sw0`/`io_sw1`.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, CNT_W = 4.
- Clean rise: reset, then `sw0_raw` 0→1 and held. Response:
  - `io_sw0` = 1 and `sw_rise[0]` = 1 for one cycle at edge 5 after the capture edge.
  - `sw_changed[0]` = 1 and stays 1.
- Bounce rejection: `sw1_raw` toggles 1,0,1,0 with 2-cycle dwell, then settles at 1. Response:
  - No output change during the bounce.
  - `io_sw1` rises 5 edges after the final capture.
  - Exactly one `sw_rise[1]` pulse.
- Fall and clear: starting from `io_sw0` = 1, drive `sw0_raw` to 0. Response:
  - `sw_fall[0]` pulses once.
  - Pulse `changed_clr[0]` → `sw_changed[0]` = 0 at the next edge.
- Set/clear collision: assert `changed_clr[1]` in the same cycle as an accepted `sw1` transition → `sw_changed[1]` remains 1.
- Reset mid-count: start a 0→1 on `sw0_raw`, then assert `reset` at count 2 → all outputs 0 at the next edge; the count restarts from 0 after release.
- Simultaneous channels: both raw inputs rise on the same edge → `io_sw0`, `io_sw1`, `sw_rise` = 2'b11 on the same cycle.

Source files
------------

// File: rtl/pmipsl_io_pkg.sv
// Shared definitions for the PMIPSL board I/O conditioning logic.
// Holds the switch count, debouncer FSM encoding and default timing.
package pmipsl_io_pkg;

   localparam int NUM_SW              = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 1000;
   localparam int CNT_W_DEF           = 16;

   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_COUNTING = 1'b1
   } db_state_t;

   // Registered per-channel results, gathered into vectors by the top.
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic changed;
   } chan_out_t;

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: 2-flop synchronizer, counting debouncer FSM,
// direction pulses and a sticky change flag. Every output is a flop.
module sw_debounce_chan
   import pmipsl_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      raw,
   input  logic      changed_clr,
   output chan_out_t out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1, sync2;
   logic [CNT_W-1:0] cnt;
   db_state_t        state;
   logic             accept;

   // A single-cycle debounce accepts straight out of STABLE.
   always_comb begin
      accept = 1'b0;
      if (sync2 != out.level) begin
         if (state == DB_COUNTING)
            accept = (cnt == CNT_LAST);
         else
            accept = (CNT_LAST == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         cnt         <= '0;
         state       <= DB_STABLE;
         out.level   <= 1'b0;
         out.rise    <= 1'b0;
         out.fall    <= 1'b0;
         out.changed <= 1'b0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         out.rise <= 1'b0;
         out.fall <= 1'b0;

         if (sync2 == out.level) begin
            // Matches the accepted level: idle, or a bounce to discard.
            state <= DB_STABLE;
            cnt   <= '0;
         end else if (accept) begin
            out.level <= sync2;
            out.rise  <= sync2;
            out.fall  <= ~sync2;
            state     <= DB_STABLE;
            cnt       <= '0;
         end else if (state == DB_STABLE) begin
            state <= DB_COUNTING;
            cnt   <= CNT_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // Set has priority over a coincident clear.
         if (accept)
            out.changed <= 1'b1;
         else if (changed_clr)
            out.changed <= 1'b0;
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Two-channel slide-switch conditioner feeding DMemory_IO switch inputs.
// Channels are independent instances of sw_debounce_chan.
module switch_debouncer
   import pmipsl_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sw0_raw,
   input  logic              sw1_raw,
   output logic              io_sw0,
   output logic              io_sw1,
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall,
   output logic [NUM_SW-1:0] sw_changed,
   input  logic [NUM_SW-1:0] changed_clr
);

   logic [NUM_SW-1:0] raw_vec;
   logic [NUM_SW-1:0] level_vec;
   chan_out_t         chan_out [NUM_SW];

   assign raw_vec = {sw1_raw, sw0_raw};

   for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
      sw_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .raw         (raw_vec[i]),
         .changed_clr (changed_clr[i]),
         .out         (chan_out[i])
      );

      assign level_vec[i]  = chan_out[i].level;
      assign sw_rise[i]    = chan_out[i].rise;
      assign sw_fall[i]    = chan_out[i].fall;
      assign sw_changed[i] = chan_out[i].changed;
   end

   assign io_sw0 = level_vec[0];
   assign io_sw1 = level_vec[1];

endmodule
